// File: rtl/reg_bank_scheduler_pkg.sv
// Shared types for the register-bank write scheduler: FSM encoding and index-width helper.
package reg_bank_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Width of an index into n items, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_scheduler_rr_picker.sv
// Combinational round-robin pick: first requester after ptr_i, wrapping, wins.
module reg_bank_scheduler_rr_picker
  import reg_bank_scheduler_pkg::*;
#(
  parameter  int unsigned NumReq = 4,
  localparam int unsigned IdxW   = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_c_o,
  output logic [IdxW-1:0]   idx_c_o
);

  logic            found;
  logic [IdxW-1:0] cand;

  // Scan from ptr+1 upward so the last winner has lowest priority.
  always_comb begin
    gnt_c_o = '0;
    idx_c_o = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      cand = IdxW'((32'(ptr_i) + i) % NumReq);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        gnt_c_o[cand] = 1'b1;
        idx_c_o       = cand;
      end
    end
  end

endmodule

// File: rtl/reg_bank_scheduler.sv
// Round-robin shared register bank with optional burst lock and a registered read port.
module reg_bank_scheduler
  import reg_bank_scheduler_pkg::*;
#(
  parameter int unsigned Size    = 8,
  parameter int unsigned Depth   = 8,
  parameter int unsigned AddrW   = 3,
  parameter int unsigned NumReq  = 4,
  parameter int unsigned LockMax = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_i,
  input  logic [NumReq-1:0]       lock_i,
  input  logic [NumReq*AddrW-1:0] addr_i,
  input  logic [NumReq*Size-1:0]  data_i,
  output logic [NumReq-1:0]       ack_o,
  output logic [NumReq-1:0]       owner_o,
  output logic                    busy_o,
  input  logic [AddrW-1:0]        rd_addr_i,
  output logic [Size-1:0]         rd_data_o
);

  localparam int unsigned IdxW = idx_width(NumReq);
  localparam int unsigned CntW = $clog2(LockMax + 1);

  state_e            state_q;
  logic [IdxW-1:0]   ptr_q;
  logic [IdxW-1:0]   win_q;
  logic [CntW-1:0]   cnt_q;
  logic [CntW-1:0]   cnt_d;
  logic [AddrW-1:0]  addr_q;
  logic [Size-1:0]   data_q;
  logic [NumReq-1:0] ack_q;
  logic [NumReq-1:0] owner_q;
  logic              busy_q;
  logic [Size-1:0]   rd_q;
  logic [Size-1:0]   bank_q [Depth];

  logic [NumReq-1:0] pick_gnt;
  logic [IdxW-1:0]   pick_idx;
  logic [NumReq-1:0] win_oh;

  reg_bank_scheduler_rr_picker #(
    .NumReq (NumReq)
  ) u_picker (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_c_o (pick_gnt),
    .idx_c_o (pick_idx)
  );

  assign cnt_d  = cnt_q + CntW'(1);
  assign win_oh = NumReq'(1) << win_q;

  // FSM, bank and read register; all outputs come straight from flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ptr_q   <= IdxW'(NumReq - 1);
      win_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      rd_q    <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      ack_q <= '0;
      // Read samples the bank before this edge's write lands: same-address read sees old data.
      rd_q  <= (32'(rd_addr_i) < Depth) ? bank_q[rd_addr_i] : '0;
      unique case (state_q)
        ST_IDLE: begin
          if (|req_i) begin
            win_q   <= pick_idx;
            addr_q  <= addr_i[32'(pick_idx)*AddrW +: AddrW];
            data_q  <= data_i[32'(pick_idx)*Size +: Size];
            owner_q <= pick_gnt;
            busy_q  <= 1'b1;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (32'(addr_q) < Depth) begin
            bank_q[addr_q] <= data_q;
          end
          ack_q <= win_oh;
          ptr_q <= win_q;
          if (lock_i[win_q] && (32'(cnt_d) < LockMax)) begin
            cnt_q   <= cnt_d;
            state_q <= ST_LOCKED;
          end else begin
            cnt_q   <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (req_i[win_q]) begin
            addr_q  <= addr_i[32'(win_q)*AddrW +: AddrW];
            data_q  <= data_i[32'(win_q)*Size +: Size];
            state_q <= ST_WRITE;
          end else if (!lock_i[win_q]) begin
            cnt_q   <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack_o     = ack_q;
  assign owner_o   = owner_q;
  assign busy_o    = busy_q;
  assign rd_data_o = rd_q;

endmodule

// File: tb/tb_reg_bank_scheduler.sv
// Directed bench for reg_bank_scheduler with a six-entry bank and four writers.
module tb_reg_bank_scheduler;

  localparam int unsigned Size    = 8;
  localparam int unsigned Depth   = 6;
  localparam int unsigned AddrW   = 3;
  localparam int unsigned NumReq  = 4;
  localparam int unsigned LockMax = 4;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic [NumReq-1:0]       req_i;
  logic [NumReq-1:0]       lock_i;
  logic [NumReq*AddrW-1:0] addr_i;
  logic [NumReq*Size-1:0]  data_i;
  logic [NumReq-1:0]       ack_o;
  logic [NumReq-1:0]       owner_o;
  logic                    busy_o;
  logic [AddrW-1:0]        rd_addr_i;
  logic [Size-1:0]         rd_data_o;

  int n_cmp = 0;
  int n_err = 0;

  reg_bank_scheduler #(
    .Size    (Size),
    .Depth   (Depth),
    .AddrW   (AddrW),
    .NumReq  (NumReq),
    .LockMax (LockMax)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .lock_i    (lock_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .ack_o     (ack_o),
    .owner_o   (owner_o),
    .busy_o    (busy_o),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_wr(input int k, input logic [AddrW-1:0] a, input logic [Size-1:0] d);
    addr_i[k*AddrW +: AddrW] = a;
    data_i[k*Size +: Size]   = d;
  endtask

  task automatic do_reset();
    req_i  = '0;
    lock_i = '0;
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    req_i     = '0;
    lock_i    = '0;
    addr_i    = '0;
    data_i    = '0;
    rd_addr_i = '0;
    do_reset();

    check("rst_ack",   32'(ack_o),     32'h0);
    check("rst_owner", 32'(owner_o),   32'h0);
    check("rst_busy",  32'(busy_o),    32'h0);
    check("rst_rd",    32'(rd_data_o), 32'h0);

    // Single write from writer 0, then read it back.
    set_wr(0, 3'd2, 8'hA5);
    req_i = 4'b0001;
    tick();
    check("t1_owner",  32'(owner_o), 32'h1);
    check("t1_busy",   32'(busy_o),  32'h1);
    check("t1_noack",  32'(ack_o),   32'h0);
    tick();
    check("t1_ack",    32'(ack_o),   32'h1);
    check("t1_idle",   32'(busy_o),  32'h0);
    req_i     = '0;
    rd_addr_i = 3'd2;
    tick();
    check("t1_rd",     32'(rd_data_o), 32'hA5);
    check("t1_ackoff", 32'(ack_o),     32'h0);

    // Round-robin order with all writers requesting continuously.
    do_reset();
    for (int k = 0; k < 4; k++) set_wr(k, AddrW'(k), Size'(8'h10 + k));
    req_i = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      check($sformatf("t2_gap%0d", n), 32'(ack_o), 32'h0);
      tick();
      check($sformatf("t2_ack%0d", n), 32'(ack_o), 32'h1 << exp_order[n]);
    end
    req_i = '0;
    rd_addr_i = 3'd3;
    tick();
    tick();
    check("t2_rd3", 32'(rd_data_o), 32'h13);

    // Burst lock by writer 1 while writer 2 waits; forced release after four writes.
    do_reset();
    set_wr(1, 3'd4, 8'h41);
    set_wr(2, 3'd0, 8'h52);
    req_i  = 4'b0110;
    lock_i = 4'b0010;
    for (int n = 0; n < 4; n++) begin
      tick();
      check($sformatf("t3_gap%0d", n),   32'(ack_o),   32'h0);
      check($sformatf("t3_own%0d", n),   32'(owner_o), 32'h2);
      tick();
      check($sformatf("t3_ack%0d", n),   32'(ack_o),   32'h2);
      check($sformatf("t3_busy%0d", n),  32'(busy_o),  (n < 3) ? 32'h1 : 32'h0);
    end
    tick();
    check("t3_w2_own", 32'(owner_o), 32'h4);
    tick();
    check("t3_w2_ack", 32'(ack_o),   32'h4);
    req_i  = '0;
    lock_i = '0;

    // Same-edge read and write of address 5 returns the old value.
    set_wr(0, 3'd5, 8'h11);
    req_i = 4'b0001;
    tick();
    tick();
    check("t4_ack_old", 32'(ack_o), 32'h1);
    set_wr(0, 3'd5, 8'h22);
    tick();
    rd_addr_i = 3'd5;
    tick();
    check("t4_ack_new", 32'(ack_o),     32'h1);
    check("t4_rd_old",  32'(rd_data_o), 32'h11);
    req_i = '0;
    tick();
    check("t4_rd_new",  32'(rd_data_o), 32'h22);

    // Out-of-range address 7 is acked but never stored.
    set_wr(3, 3'd7, 8'h5A);
    req_i = 4'b1000;
    tick();
    tick();
    check("t5_ack", 32'(ack_o), 32'h8);
    req_i     = '0;
    rd_addr_i = 3'd7;
    tick();
    check("t5_rd7", 32'(rd_data_o), 32'h0);
    rd_addr_i = 3'd5;
    tick();
    check("t5_rd5", 32'(rd_data_o), 32'h22);

    // Reset during WRITE drops the write and clears everything.
    set_wr(1, 3'd1, 8'h77);
    req_i = 4'b0010;
    tick();
    check("t6_busy_pre", 32'(busy_o), 32'h1);
    rst_ni = 1'b0;
    #2;
    check("t6_ack",   32'(ack_o),     32'h0);
    check("t6_owner", 32'(owner_o),   32'h0);
    check("t6_busy",  32'(busy_o),    32'h0);
    check("t6_rd",    32'(rd_data_o), 32'h0);
    req_i = '0;
    tick();
    check("t6_ack_hold", 32'(ack_o), 32'h0);
    rst_ni    = 1'b1;
    rd_addr_i = 3'd5;
    tick();
    check("t6_bank5", 32'(rd_data_o), 32'h0);
    rd_addr_i = 3'd1;
    tick();
    check("t6_bank1", 32'(rd_data_o), 32'h0);
    req_i = 4'b1111;
    tick();
    check("t6_first_own", 32'(owner_o), 32'h1);
    tick();
    check("t6_first_ack", 32'(ack_o),   32'h1);
    req_i = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
